cpu_sequencer: RTL and testbench

Eight-phase control sequencer for the 8-bit accumulator CPU. It steps every instruction through eight clock phases, S0..S7, and drives the strobes that run the datapath:
- byte fetch into the instruction register;
- PC increment and load;
- accumulator load;
- memory read/write;
- data-bus drive enable;
- halt.

It sits inside `cpu` directly upstream of the address mux, ALU and accumulator. It produces the `rd`/`wr` traffic that `ram` and `rom` consume.

---
 rtl/cpu_sequencer.sv | 129 ++++++++++++
 tb/tb_cpu_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - eight-phase control sequencer for the 8-bit accumulator CPU
// Optional single-step hold at S7 when SEQ_STEP_EN is defined.
module cpu_sequencer #(
   parameter logic [2:0] HLT = 3'h0,
   parameter logic [2:0] SKZ = 3'h1,
   parameter logic [2:0] STO = 3'h6,
   parameter logic [2:0] JMP = 3'h7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ena,
   input  logic [2:0] opcode,
   input  logic       zero,
`ifdef SEQ_STEP_EN
   input  logic       step,
`endif
   output logic       fetch,
   output logic       ir_hi,
   output logic       load_ir,
   output logic       rd,
   output logic       wr,
   output logic       inc_pc,
   output logic       load_pc,
   output logic       load_acc,
   output logic       datactl_ena,
   output logic       halt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_t;

   state_t state_q, state_d;
   logic   running_q, running_d;
   logic   halted_q, halted_d;
   logic   skip_q, skip_d;
   logic   wrap_ok;
   logic   active;
   logic   is_alu;

`ifdef SEQ_STEP_EN
   assign wrap_ok = step;
`else
   assign wrap_ok = 1'b1;
`endif

   assign active = running_q & ena & ~halted_q;
   assign is_alu = (opcode != HLT) && (opcode != SKZ) && (opcode != STO) && (opcode != JMP);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S0;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
         skip_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         running_q <= running_d;
         halted_q  <= halted_d;
         skip_q    <= skip_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      running_d = running_q;
      halted_d  = halted_q;
      skip_d    = skip_q;
      if (!running_q) begin
         state_d = S0;
         if (ena) running_d = 1'b1;
      end else if (active) begin
         // HLT freezes the phase at S3; only reset leaves this condition
         if (state_q == S3 && opcode == HLT) begin
            halted_d = 1'b1;
         end else if (state_q == S7) begin
            if (wrap_ok) begin
               state_d = S0;
               skip_d  = 1'b0;
            end
         end else begin
            state_d = state_t'(state_q + 3'd1);
            if (state_q == S4) skip_d = (opcode == SKZ) & zero;
         end
      end
   end

   always_comb begin
      fetch       = 1'b0;
      ir_hi       = 1'b0;
      load_ir     = 1'b0;
      rd          = 1'b0;
      wr          = 1'b0;
      inc_pc      = 1'b0;
      load_pc     = 1'b0;
      load_acc    = 1'b0;
      datactl_ena = 1'b0;
      halt        = halted_q;
      if (active) begin
         case (state_q)
            S0: begin rd = 1'b1; load_ir = 1'b1; ir_hi = 1'b1; inc_pc = 1'b1; fetch = 1'b1; end
            S1: begin rd = 1'b1; load_ir = 1'b1; inc_pc = 1'b1; fetch = 1'b1; end
            S2: fetch = 1'b1;
            S3: begin fetch = 1'b1; halt = (opcode == HLT); end
            S4: begin
               rd          = is_alu;
               datactl_ena = (opcode == STO);
               load_pc     = (opcode == JMP);
            end
            S5: begin
               rd          = is_alu;
               load_acc    = is_alu;
               datactl_ena = (opcode == STO);
               wr          = (opcode == STO);
               load_pc     = (opcode == JMP);
               inc_pc      = (opcode == SKZ) & skip_q;
            end
            S6: begin
               rd          = is_alu;
               datactl_ena = (opcode == STO);
               inc_pc      = (opcode == SKZ) & skip_q;
            end
            default: ;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

   logic       clk = 1'b0;
   logic       reset, ena, zero, step;
   logic [2:0] opcode;
   logic       fetch, ir_hi, load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt;
   logic [2:0] state;
   logic [9:0] strobes;

   int checks   = 0;
   int failures = 0;

   cpu_sequencer dut (
      .clk(clk), .reset(reset), .ena(ena), .opcode(opcode), .zero(zero),
`ifdef SEQ_STEP_EN
      .step(step),
`endif
      .fetch(fetch), .ir_hi(ir_hi), .load_ir(load_ir), .rd(rd), .wr(wr),
      .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc),
      .datactl_ena(datactl_ena), .halt(halt), .state(state)
   );

   always #50 clk = ~clk;

   // fetch ir_hi load_ir rd wr inc_pc load_pc load_acc datactl_ena halt
   assign strobes = {fetch, ir_hi, load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt};

   localparam logic [9:0] P_S0 = 10'b1111010000;
   localparam logic [9:0] P_S1 = 10'b1011010000;
   localparam logic [9:0] P_FT = 10'b1000000000;
   localparam logic [9:0] P_Z  = 10'b0000000000;
   localparam logic [9:0] P_H  = 10'b0000000001;
   localparam logic [79:0] T_LDA  = {P_Z, 10'b0001000000, 10'b0001000100, 10'b0001000000, P_FT, P_FT, P_S1, P_S0};
   localparam logic [79:0] T_STO  = {P_Z, 10'b0000000010, 10'b0000100010, 10'b0000000010, P_FT, P_FT, P_S1, P_S0};
   localparam logic [79:0] T_JMP  = {P_Z, P_Z, 10'b0000001000, 10'b0000001000, P_FT, P_FT, P_S1, P_S0};
   localparam logic [79:0] T_SKZ1 = {P_Z, 10'b0000010000, 10'b0000010000, P_Z, P_FT, P_FT, P_S1, P_S0};
   localparam logic [79:0] T_SKZ0 = {P_Z, P_Z, P_Z, P_Z, P_FT, P_FT, P_S1, P_S0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Entered and left at a negedge in S0; pause_at freezes ena for two cycles in that phase.
   task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                            input logic [79:0] tbl, input bit toggle_z, input int pause_at);
      opcode = op;
      zero   = z;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s_state_s%0d", name, i), 32'(state), 32'(i));
         check($sformatf("%s_strb_s%0d", name, i), 32'(strobes), 32'(tbl[i*10 +: 10]));
         if (i == pause_at) begin
            ena = 1'b0;
            #1 check($sformatf("%s_pause_strb", name), 32'(strobes), 32'(P_Z));
            @(negedge clk);
            @(negedge clk);
            check($sformatf("%s_pause_state", name), 32'(state), 32'(i));
            ena = 1'b1;
            #1 check($sformatf("%s_resume_strb", name), 32'(strobes), 32'(tbl[i*10 +: 10]));
         end
         if (toggle_z && i >= 5) zero = ~zero;
         @(negedge clk);
      end
   endtask

   initial begin
      reset  = 1'b0;
      ena    = 1'b1;
      zero   = 1'b0;
      step   = 1'b1;
      opcode = 3'h5;
      @(negedge clk);
      check("rst_strb", 32'(strobes), 32'(P_Z));
      check("rst_state", 32'(state), 32'd0);
      #70 reset = 1'b1;
      @(negedge clk);
      check("idle_strb", 32'(strobes), 32'(P_Z));
      @(negedge clk);

      run_instr("lda", 3'h5, 1'b0, T_LDA, 1'b0, -1);
      run_instr("sto", 3'h6, 1'b0, T_STO, 1'b0, -1);
      run_instr("jmp", 3'h7, 1'b0, T_JMP, 1'b0, -1);
      run_instr("skz1", 3'h1, 1'b1, T_SKZ1, 1'b1, -1);
      run_instr("skz0", 3'h1, 1'b0, T_SKZ0, 1'b1, -1);
      run_instr("add_pause", 3'h2, 1'b0, T_LDA, 1'b0, 5);

      opcode = 3'h0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("hlt_strb_s%0d", i), 32'(strobes), 32'(T_LDA[i*10 +: 10]));
         @(negedge clk);
      end
      check("hlt_s3_strb", 32'(strobes), 32'(P_FT | P_H));
      @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         check($sformatf("hlt_hold_state%0d", k), 32'(state), 32'd3);
         check($sformatf("hlt_hold_strb%0d", k), 32'(strobes), 32'(P_H));
         ena = k[0];
         @(negedge clk);
      end
      ena   = 1'b1;
      reset = 1'b0;
      #1 check("hlt_rst_strb", 32'(strobes), 32'(P_Z));
      check("hlt_rst_state", 32'(state), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("restart_s0", 32'(strobes), 32'(P_S0));

      opcode = 3'h6;
      for (int i = 0; i < 5; i++) @(negedge clk);
      check("sto_mid_state", 32'(state), 32'd5);
      check("sto_mid_wr", 32'(wr), 32'd1);
      #10 reset = 1'b0;
      #1 check("sto_rst_wr", 32'(wr), 32'd0);
      check("sto_rst_strb", 32'(strobes), 32'(P_Z));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_instr("lda2", 3'h5, 1'b0, T_LDA, 1'b0, -1);

`ifdef SEQ_STEP_EN
      step   = 1'b0;
      opcode = 3'h5;
      for (int i = 0; i < 7; i++) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("step_hold_state%0d", k), 32'(state), 32'd7);
         check($sformatf("step_hold_strb%0d", k), 32'(strobes), 32'(P_Z));
         @(negedge clk);
      end
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      check("step_wrap_state", 32'(state), 32'd0);
      check("step_wrap_strb", 32'(strobes), 32'(P_S0));
      step = 1'b1;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
